// File: rtl/gray_arb_pkg.sv
// Shared types and default sizing for the Gray-code conversion arbiter.
package gray_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_N = 4;
    localparam int unsigned DEF_R = 4;

endpackage

// File: rtl/gray_serial_decoder.sv
// Bit-serial Gray-to-binary engine: one result bit per step, MSB first.
module gray_serial_decoder
    import gray_arb_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] gray_in,
    input  logic         step,
    output logic         done,
    output logic [N-1:0] binary_out
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  gray_q;
    logic [N-1:0]  bin_q;
    logic [N-1:0]  bin_next;
    logic [CW-1:0] cnt;

    // Only the bit selected by cnt changes; its upper neighbour is already final.
    always_comb begin
        bin_next = bin_q;
        for (int unsigned k = 0; k < N; k++) begin
            if (CW'(k) == cnt) begin
                if (k == N - 1) begin
                    bin_next[k] = gray_q[k];
                end else begin
                    bin_next[k] = gray_q[k] ^ bin_q[k + 1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q <= '0;
            bin_q  <= '0;
            cnt    <= '0;
        end else if (load) begin
            gray_q <= gray_in;
            bin_q  <= '0;
            cnt    <= CW'(N - 1);
        end else if (step) begin
            bin_q <= bin_next;
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done       = (cnt == '0);
    assign binary_out = bin_q;

endmodule

// File: rtl/gray_convert_arbiter.sv
// Round-robin front end sharing one serial Gray decoder among R requesters.
module gray_convert_arbiter
    import gray_arb_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned R  = DEF_R,
    parameter int unsigned IW = $clog2(R)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [R-1:0]        req_valid,
    input  logic [R-1:0][N-1:0] req_gray,
    output logic [R-1:0]        req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [N-1:0]        rsp_binary,
    output logic [IW-1:0]       rsp_id,
    output logic                busy
);

    arb_state_t    state, state_next;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] id_q;
    logic [IW-1:0] grant_idx;
    logic          grant_found;
    logic          grant;
    logic          step;
    logic          dec_done;
    logic [N-1:0]  dec_bin;

    // Search starts just past the previous winner so every requester gets a turn.
    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int unsigned i = 1; i <= R; i++) begin
            if (!grant_found) begin
                if (req_valid[(int'(last_grant) + i) % R]) begin
                    grant_idx   = IW'((int'(last_grant) + i) % R);
                    grant_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        step       = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_found) begin
                    grant      = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                step = 1'b1;
                if (dec_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IW'(R - 1);
            id_q       <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                last_grant <= grant_idx;
                id_q       <= grant_idx;
            end
        end
    end

    gray_serial_decoder #(
        .N(N)
    ) u_decoder (
        .clk       (clk),
        .rst       (rst),
        .load      (grant),
        .gray_in   (req_gray[grant_idx]),
        .step      (step),
        .done      (dec_done),
        .binary_out(dec_bin)
    );

    // Outputs are forced quiet while rst is asserted, whatever the state register holds.
    always_comb begin
        req_ready = '0;
        if (grant && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign rsp_valid  = (state == DONE) && !rst;
    assign rsp_binary = rsp_valid ? dec_bin : '0;
    assign rsp_id     = rsp_valid ? id_q : '0;
    assign busy       = (state != IDLE) && !rst;

endmodule

// File: doc/gray_convert_arbiter.md
GRAY_CONVERT_ARBITER -- requirements
Module: gray_convert_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4: code width in bits (N >= 1).
REQ-002 The block SHALL have parameter R, default 4: number of requesters (R >= 2); IW = $clog2(R).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port req_valid  input  R  per-requester request valid.
REQ-006 The block SHALL have port req_gray  input  R x N  per-requester Gray-coded value.
REQ-007 The block SHALL have port req_ready  output  R  per-requester accept strobe; at most one bit set.
REQ-008 The block SHALL have port rsp_valid  output  1  converted result valid.
REQ-009 The block SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 The block SHALL have port rsp_binary  output  N  binary result.
REQ-011 The block SHALL have port rsp_id  output  IW  index of the requester that owns the result.
REQ-012 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block SHALL share one bit-serial Gray-to-binary engine among R requesters through a three-state FSM: IDLE, CONVERT, DONE.
REQ-014 IDLE: if any req_valid is set, the block SHALL grant round-robin, searching from last_grant+1 modulo R; it SHALL assert req_ready for the granted index in the same cycle, combinationally.
REQ-015 On grant, the block SHALL capture req_gray and the index, update last_grant, load bit counter = N-1, and move to CONVERT.
REQ-016 IDLE with no req_valid: the block SHALL stay in IDLE, with req_ready all-zero.
REQ-017 CONVERT: each cycle the block SHALL compute bin[k] = gray[k] XOR bin[k+1], with bin[N] treated as 0, for k = counter, MSB first; the counter decrements each cycle.
REQ-018 The block SHALL stay in CONVERT for exactly N cycles and SHALL move to DONE after bit 0 is produced.
REQ-019 DONE: rsp_valid SHALL be 1; rsp_binary and rsp_id SHALL hold stable until rsp_ready=1; on that cycle the block SHALL move to IDLE.
REQ-020 Latency: with acceptance in cycle t, rsp_valid SHALL first be high in cycle t+N+1.
REQ-021 Minimum issue interval SHALL be N+2 cycles (rsp_ready held high).
REQ-022 req_ready SHALL be 0 in CONVERT and DONE, regardless of req_valid.
REQ-023 A requester dropping req_valid before grant SHALL NOT be served; no state changes for it.
REQ-024 rsp_binary and rsp_id SHALL be 0 whenever rsp_valid=0.
REQ-025 With N=1, CONVERT SHALL last exactly one cycle.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL set state=IDLE, counter=0, captured data=0, and last_grant=R-1, so that requester 0 has first priority.
REQ-027 During and immediately after reset, the block SHALL drive req_ready=0, rsp_valid=0, rsp_binary=0, rsp_id=0 and busy=0.
REQ-028 Reset in CONVERT or DONE SHALL abandon the transaction; no response for it is ever issued.
REQ-029 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-030 Package gray_arb_pkg SHALL hold the FSM state enum typedef (IDLE, CONVERT, DONE) and default parameter constants.
REQ-031 The bit-serial engine SHALL be sub-module gray_serial_decoder, with ports load, gray_in, step, done and binary_out.
REQ-032 Round-robin selection SHALL stay in gray_convert_arbiter; no separate arbiter module.

Verification
REQ-033 Single request (N=4, R=4): req 2, gray 4'b1101 accepted in cycle t -> rsp_valid in t+5, rsp_binary=4'b1001, rsp_id=2.
REQ-034 All four req_valid held high from reset, rsp_ready=1 -> grant order 0,1,2,3,0 with one grant every 6 cycles.
REQ-035 rsp_ready low for 10 cycles in DONE -> rsp_valid, rsp_binary and rsp_id stable throughout; req_ready stays all-zero; busy=1.
REQ-036 rst pulsed mid-CONVERT -> next cycle rsp_valid=0 and busy=0; after release, with all req_valid set, requester 0 is granted first.
REQ-037 Exhaustive sweep of all 16 gray values via requester 1 -> every result matches the reference conversion (e.g. 4'b1000 -> 4'b1111, 4'b0000 -> 4'b0000).
REQ-038 After a grant to requester 1, requests 1 and 3 are asserted together -> 3 is served next, then 1.
